hash_ptr_table_pipe: RTL and testbench
======================================

// Module: hash_ptr_table_pipe
// PURPOSE
//  Parametrised LZRW1 hash-indexed pointer table for the compressor match path.
//  Per accepted byte: reads the last position stored at the hash index, judges hit/miss against
//  the offset window, writes the current position back, and returns the result one cycle later.
//  Per-entry valid bits replace the "stored position == 0" empty test. Table flush is a
//  sequenced sweep. Sits between the hash unit and the comparator / compressed-value packer.
// PARAMETERS
//  HASH_W  12  hash index width; table depth DEPTH = 2**HASH_W
//  POS_W   32  byte-position width
//  OFF_W   12  offset width; match window WINDOW = 2**OFF_W
// PORTS
//  clock         in   1       single clock; all logic on posedge
//  reset_n       in   1       asynchronous, active-low reset
//  clear         in   1       sync pulse: flush table (invalidate all entries)
//  in_valid      in   1       request valid
//  in_ready      out  1       request accepted when in_valid && in_ready
//  in_hash       in   HASH_W  table index from hash unit
//  in_pos        in   POS_W   current byte position
//  in_byte       in   8       current literal byte
//  out_valid     out  1       result valid
//  out_ready     in   1       result consumed when out_valid && out_ready
//  out_hit       out  1       1 = match candidate (control bit)
//  out_offset    out  OFF_W   in_pos - old_pos on hit, else 0
//  out_old_pos   out  POS_W   stored position read (0 if entry invalid)
//  out_byte      out  8       in_byte on miss, 0 on hit
//  hit_count     out  32      hits since reset/clear (stats build only)
//  miss_count    out  32      misses since reset/clear (stats build only)
// BEHAVIOUR
//  - Reset (reset_n low, async): FSM=SWEEP, sweep index=0, out_valid=0, out_hit=0,
//    out_offset=0, out_old_pos=0, out_byte=0, in_ready=0, counters=0. Table data has no reset.
//  - FSM SWEEP: clears valid[idx] one entry per cycle, idx 0..DEPTH-1; exactly DEPTH cycles;
//    in_ready=0 throughout; goes to RUN after idx=DEPTH-1.
//  - FSM RUN: in_ready = !out_valid || out_ready (one-deep output register, no bubble).
//  - clear=1 in RUN: -> SWEEP next cycle; a request accepted in the same cycle still completes
//    and its result is held until consumed; table write of that request is overridden by sweep.
//    clear during SWEEP restarts sweep at idx 0.
//  - Accept: old=table[in_hash]; v=valid[in_hash]; d=in_pos-old (POS_W bits, modular);
//    hit = v && d!=0 && d<WINDOW. Same edge: table[in_hash]<=in_pos, valid[in_hash]<=1.
//  - Result registered on accepting edge: latency 1 cycle; out_offset=hit?d[OFF_W-1:0]:0;
//    out_old_pos=v?old:0; out_byte=hit?0:in_byte. Held stable while out_valid && !out_ready.
//  - Back-to-back same in_hash: second request sees first's position (write precedes read).
//  - Position wrap: d modular, so old=2**POS_W-2, in_pos=3 gives d=5 -> hit.
//  - d>=WINDOW or d==0 -> miss; entry still overwritten with in_pos.
// CONFIGURATION
//  HPT_STATS_EN defined: hit_count/miss_count increment per accepted request, saturate at
//   2**32-1, zeroed by reset and by clear entering SWEEP.
//  HPT_STATS_EN undefined: ports present, tied to 0; no counter logic.
// TESTING
//  Release reset_n -> in_ready=0 for exactly 4096 cycles, then 1; outputs all 0.
//  hash=0x123,pos=5,byte=0x41 -> next cycle out_valid,hit=0,offset=0,old_pos=0,byte=0x41.
//  then hash=0x123,pos=20,byte=0x42 -> hit=1,offset=15,old_pos=5,byte=0x00.
//  hash=0x010 pos=100, then hash=0x010 pos=4196 -> hit=0 (d=4096), old_pos=100, byte passthrough.
//  out_ready=0 for 5 cycles with result pending -> in_ready=0, outputs stable; release -> no loss.
//  clear pulse after 10 hits -> 4096-cycle sweep, re-lookup of prior hash misses; with
//   HPT_STATS_EN counters read 10/x before clear and 0/0 after.

Source files
------------

// File: rtl/hash_ptr_table_pipe.sv
// LZRW1 hash-indexed pointer table: one lookup/update per accepted byte, registered result.
// Optional hit/miss statistics are compiled in when HPT_STATS_EN is defined.
module hash_ptr_table_pipe #(
  parameter int HASH_W = 12,
  parameter int POS_W  = 32,
  parameter int OFF_W  = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HASH_W-1:0] in_hash,
  input  logic [POS_W-1:0]  in_pos,
  input  logic [7:0]        in_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_hit,
  output logic [OFF_W-1:0]  out_offset,
  output logic [POS_W-1:0]  out_old_pos,
  output logic [7:0]        out_byte,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int DEPTH = 1 << HASH_W;

  typedef enum logic {ST_SWEEP, ST_RUN} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [HASH_W-1:0]   r_sweep_idx;
  logic [HASH_W-1:0]   w_sweep_idx_next;

  logic [POS_W-1:0]    r_table [DEPTH];
  logic                r_valid_bits [DEPTH];

  logic                r_out_valid;
  logic                r_out_hit;
  logic [OFF_W-1:0]    r_out_offset;
  logic [POS_W-1:0]    r_out_old_pos;
  logic [7:0]          r_out_byte;

  logic                w_accept;
  logic [POS_W-1:0]    w_old;
  logic                w_v;
  logic [POS_W-1:0]    w_d;
  logic                w_hit;

  always_comb begin
    w_state_next     = r_state;
    w_sweep_idx_next = r_sweep_idx;
    case (r_state)
      ST_SWEEP: begin
        if (clear) begin
          w_sweep_idx_next = '0;
        end else if (&r_sweep_idx) begin
          w_state_next     = ST_RUN;
          w_sweep_idx_next = '0;
        end else begin
          w_sweep_idx_next = r_sweep_idx + 1'b1;
        end
      end
      default: begin
        if (clear) begin
          w_state_next     = ST_SWEEP;
          w_sweep_idx_next = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_SWEEP;
      r_sweep_idx <= '0;
    end else begin
      r_state     <= w_state_next;
      r_sweep_idx <= w_sweep_idx_next;
    end
  end

  assign in_ready = (r_state == ST_RUN) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // Asynchronous read so a same-index request on the next cycle sees the fresh write.
  assign w_old = r_table[in_hash];
  assign w_v   = r_valid_bits[in_hash];
  assign w_d   = in_pos - w_old;
  assign w_hit = w_v && (w_d != '0) && (w_d[POS_W-1:OFF_W] == '0);

  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_table[in_hash] <= in_pos;
    end
  end

  always_ff @(posedge clock) begin
    if (r_state == ST_SWEEP) begin
      r_valid_bits[r_sweep_idx] <= 1'b0;
    end else if (w_accept) begin
      r_valid_bits[in_hash] <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid   <= 1'b0;
      r_out_hit     <= 1'b0;
      r_out_offset  <= '0;
      r_out_old_pos <= '0;
      r_out_byte    <= '0;
    end else if (w_accept) begin
      r_out_valid   <= 1'b1;
      r_out_hit     <= w_hit;
      r_out_offset  <= w_hit ? w_d[OFF_W-1:0] : '0;
      r_out_old_pos <= w_v ? w_old : '0;
      r_out_byte    <= w_hit ? 8'h00 : in_byte;
    end else if (out_ready) begin
      r_out_valid   <= 1'b0;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_hit     = r_out_hit;
  assign out_offset  = r_out_offset;
  assign out_old_pos = r_out_old_pos;
  assign out_byte    = r_out_byte;

`ifdef HPT_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (clear) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_accept) begin
      if (w_hit && !(&r_hit_cnt)) begin
        r_hit_cnt <= r_hit_cnt + 1'b1;
      end
      if (!w_hit && !(&r_miss_cnt)) begin
        r_miss_cnt <= r_miss_cnt + 1'b1;
      end
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_hash_ptr_table_pipe.sv
// Directed bench for hash_ptr_table_pipe: driver pushes expected results, monitor pops on handshake.
module tb_hash_ptr_table_pipe;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_hash = '0;
  logic [31:0] in_pos = '0;
  logic [7:0]  in_byte = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_hit;
  logic [11:0] out_offset;
  logic [31:0] out_old_pos;
  logic [7:0]  out_byte;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  typedef struct packed {
    logic        hit;
    logic [11:0] off;
    logic [31:0] old;
    logic [7:0]  b;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_tx = 0;
  int   n_rx = 0;

  hash_ptr_table_pipe dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_hash     (in_hash),
    .in_pos      (in_pos),
    .in_byte     (in_byte),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_hit     (out_hit),
    .out_offset  (out_offset),
    .out_old_pos (out_old_pos),
    .out_byte    (out_byte),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every consumed result against the oldest expectation.
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 64'(out_old_pos), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          n_rx++;
          chk("out_hit", 64'(out_hit), 64'(e.hit));
          chk("out_offset", 64'(out_offset), 64'(e.off));
          chk("out_old_pos", 64'(out_old_pos), 64'(e.old));
          chk("out_byte", 64'(out_byte), 64'(e.b));
          $display("rx #%0d hit=%0d off=%0d old=0x%0h byte=0x%0h", n_rx, out_hit, out_offset,
                   out_old_pos, out_byte);
        end
      end
    end
  end

  task automatic send(input logic [11:0] h, input logic [31:0] p, input logic [7:0] b,
                      input logic eh, input logic [11:0] eo, input logic [31:0] eold,
                      input logic [7:0] eb);
    int w = 0;
    exp_t e;
    in_valid = 1'b1;
    in_hash  = h;
    in_pos   = p;
    in_byte  = b;
    @(negedge clock);
    while (!in_ready && w < 100) begin
      w++;
      @(negedge clock);
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
    end else begin
      e.hit = eh; e.off = eo; e.old = eold; e.b = eb;
      sb.push_back(e);
      n_tx++;
      $display("tx #%0d hash=0x%0h pos=0x%0h byte=0x%0h", n_tx, h, p, b);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 100) begin
      w++;
      @(negedge clock);
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic count_sweep(input string name);
    int cnt = 0;
    while (cnt < 5000) begin
      @(negedge clock);
      if (in_ready) break;
      cnt++;
    end
    chk(name, 64'(cnt), 64'd4096);
  endtask

  initial begin
    logic [31:0] exp_hits_pre;
    logic [31:0] exp_miss_pre;
    logic [31:0] exp_miss_post;
`ifdef HPT_STATS_EN
    exp_hits_pre  = 32'd10;
    exp_miss_pre  = 32'd14;
    exp_miss_post = 32'd2;
`else
    exp_hits_pre  = 32'd0;
    exp_miss_pre  = 32'd0;
    exp_miss_post = 32'd0;
`endif

    repeat (3) @(negedge clock);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_fields", {out_hit, out_offset, out_old_pos, out_byte}, 64'd0);
    chk("rst_counters", {hit_count, miss_count}, 64'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    count_sweep("reset_sweep_cycles");
    chk("post_sweep_out_valid", 64'(out_valid), 64'd0);
    @(posedge clock);
    #1;

    // Miss then hit on the same index, back to back.
    send(12'h123, 32'd5,  8'h41, 1'b0, 12'd0,  32'd0, 8'h41);
    send(12'h123, 32'd20, 8'h42, 1'b1, 12'd15, 32'd5, 8'h00);
    // Distance equal to window, then zero distance.
    send(12'h010, 32'd100,  8'h55, 1'b0, 12'd0, 32'd0,    8'h55);
    send(12'h010, 32'd4196, 8'h56, 1'b0, 12'd0, 32'd100,  8'h56);
    send(12'h010, 32'd4196, 8'h57, 1'b0, 12'd0, 32'd4196, 8'h57);
    // Position wrap-around.
    send(12'h200, 32'hFFFF_FFFE, 8'h60, 1'b0, 12'd0, 32'd0,           8'h60);
    send(12'h200, 32'd3,         8'h61, 1'b1, 12'd5, 32'hFFFF_FFFE,   8'h00);
    // Largest in-window distance.
    send(12'h300, 32'd1000, 8'h70, 1'b0, 12'd0,    32'd0,    8'h70);
    send(12'h300, 32'd5095, 8'h71, 1'b1, 12'd4095, 32'd1000, 8'h00);
    // Seven more hits with offsets 1..7.
    for (int i = 0; i < 7; i++) begin
      send(12'h400 + 12'(i), 32'd1000 + 32'(i), 8'h80 + 8'(i),
           1'b0, 12'd0, 32'd0, 8'h80 + 8'(i));
      send(12'h400 + 12'(i), 32'd1001 + 32'(2 * i), 8'h90 + 8'(i),
           1'b1, 12'(i + 1), 32'd1000 + 32'(i), 8'h00);
    end
    drain();

    // Output back-pressure: result must hold for 5 cycles, no new acceptance.
    out_ready = 1'b0;
    send(12'h500, 32'd50, 8'h77, 1'b0, 12'd0, 32'd0, 8'h77);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_fields", {out_hit, out_offset, out_old_pos, out_byte}, {1'b0, 12'd0, 32'd0, 8'h77, 11'd0} >> 11);
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    drain();
    @(negedge clock);
    chk("hit_count_pre_clear", 64'(hit_count), 64'(exp_hits_pre));
    chk("miss_count_pre_clear", 64'(miss_count), 64'(exp_miss_pre));

    // Flush, then previously stored indices must miss.
    @(posedge clock);
    #1;
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    count_sweep("clear_sweep_cycles");
    chk("counters_after_clear", {hit_count, miss_count}, 64'd0);
    @(posedge clock);
    #1;
    send(12'h123, 32'd30,   8'h43, 1'b0, 12'd0, 32'd0, 8'h43);
    send(12'h400, 32'd2000, 8'h44, 1'b0, 12'd0, 32'd0, 8'h44);
    drain();
    @(negedge clock);
    chk("hit_count_post", 64'(hit_count), 64'd0);
    chk("miss_count_post", 64'(miss_count), 64'(exp_miss_post));
    chk("no_loss", 64'(n_rx), 64'(n_tx));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
